// File: rtl/smp_dmem_arbiter.sv
// Grants one NUM_CPU-port line read/write at a time onto the shared d_mem; strobe 1 cycle after the request,
// done pulse 1 cycle after mem_rdy; requesters hold re/we until their done pulse, losers simply wait.
module smp_dmem_arbiter #(
   parameter int NUM_CPU     = 2,
   parameter int ADDR_W      = 16,
   parameter int LINE_W      = 64,
   parameter int RR_MODE     = 1,
   parameter int TIMEOUT_CYC = 0
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_CPU-1:0]        i_req_re,
   input  logic [NUM_CPU-1:0]        i_req_we,
   input  logic [NUM_CPU*ADDR_W-1:0] i_req_addr,
   input  logic [NUM_CPU*LINE_W-1:0] i_req_wdata,
   output logic [NUM_CPU-1:0]        o_gnt,
   output logic [NUM_CPU-1:0]        o_rsp_rdy,
   output logic                      o_rsp_err,
   output logic [LINE_W-1:0]         o_rsp_rdata,
   output logic                      o_busy,
   output logic [ADDR_W-1:0]         o_mem_addr,
   output logic                      o_mem_re,
   output logic                      o_mem_we,
   output logic [LINE_W-1:0]         o_mem_wdata,
   input  logic [LINE_W-1:0]         i_mem_rdata,
   input  logic                      i_mem_rdy
);

   localparam int IDX_W = (NUM_CPU > 1) ? $clog2(NUM_CPU) : 1;
   localparam int CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
   localparam logic [CNT_W-1:0]   CNT_LAST = (TIMEOUT_CYC > 0) ? CNT_W'(TIMEOUT_CYC - 1) : '0;
   localparam logic [IDX_W-1:0]   IDX_LAST = IDX_W'(NUM_CPU - 1);
   localparam logic [NUM_CPU-1:0] ONE_HOT0 = NUM_CPU'(1);

   typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP} state_t;

   state_t              r_state;
   logic [IDX_W-1:0]    r_ptr;
   logic [IDX_W-1:0]    r_win;
   logic                r_we_op;
   logic [CNT_W-1:0]    r_cnt;
   logic [NUM_CPU-1:0]  r_gnt;
   logic [NUM_CPU-1:0]  r_rsp_rdy;
   logic                r_rsp_err;
   logic [LINE_W-1:0]   r_rsp_rdata;
   logic                r_busy;
   logic [ADDR_W-1:0]   r_mem_addr;
   logic                r_mem_re;
   logic                r_mem_we;
   logic [LINE_W-1:0]   r_mem_wdata;

   logic [NUM_CPU-1:0]  w_req;
   logic                w_found;
   logic [IDX_W-1:0]    w_idx;
   logic [IDX_W-1:0]    w_win;
   logic [ADDR_W-1:0]   w_addr;
   logic [LINE_W-1:0]   w_wdata;
   logic                w_op_we;

   assign w_req   = i_req_re | i_req_we;
   assign w_op_we = i_req_we[w_win];

   // First requester found scanning from r_ptr (round-robin) or from port 0 (fixed).
   always_comb begin
      w_found = 1'b0;
      w_win   = '0;
      w_idx   = '0;
      for (int k = 0; k < NUM_CPU; k++) begin
         if (RR_MODE != 0) w_idx = IDX_W'((int'(r_ptr) + k) % NUM_CPU);
         else              w_idx = IDX_W'(k);
         if (!w_found && w_req[w_idx]) begin
            w_found = 1'b1;
            w_win   = w_idx;
         end
      end
   end

   always_comb begin
      w_addr  = '0;
      w_wdata = '0;
      for (int i = 0; i < NUM_CPU; i++) begin
         if (w_win == IDX_W'(i)) begin
            w_addr  = i_req_addr[i*ADDR_W +: ADDR_W];
            w_wdata = i_req_wdata[i*LINE_W +: LINE_W];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_ptr       <= '0;
         r_win       <= '0;
         r_we_op     <= 1'b0;
         r_cnt       <= '0;
         r_gnt       <= '0;
         r_rsp_rdy   <= '0;
         r_rsp_err   <= 1'b0;
         r_rsp_rdata <= '0;
         r_busy      <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_re    <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_wdata <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_found) begin
                  r_win       <= w_win;
                  r_we_op     <= w_op_we;
                  r_gnt       <= ONE_HOT0 << w_win;
                  r_busy      <= 1'b1;
                  r_mem_addr  <= w_addr;
                  r_mem_wdata <= w_wdata;
                  r_mem_re    <= ~w_op_we;
                  r_mem_we    <= w_op_we;
                  r_state     <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               r_mem_re <= 1'b0;
               r_mem_we <= 1'b0;
               r_cnt    <= '0;
               r_state  <= ST_WAIT;
            end
            ST_WAIT: begin
               if (i_mem_rdy) begin
                  if (!r_we_op) r_rsp_rdata <= i_mem_rdata;
                  r_gnt     <= '0;
                  r_rsp_rdy <= ONE_HOT0 << r_win;
                  r_rsp_err <= 1'b0;
                  r_state   <= ST_RESP;
               end else if ((TIMEOUT_CYC > 0) && (r_cnt == CNT_LAST)) begin
                  // Abort: the line is never captured, the requester sees the error flag.
                  r_gnt     <= '0;
                  r_rsp_rdy <= ONE_HOT0 << r_win;
                  r_rsp_err <= 1'b1;
                  r_state   <= ST_RESP;
               end else if (r_cnt != '1) begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            ST_RESP: begin
               r_rsp_rdy <= '0;
               r_rsp_err <= 1'b0;
               r_busy    <= 1'b0;
               r_cnt     <= '0;
               if (RR_MODE != 0) r_ptr <= (r_win == IDX_LAST) ? '0 : r_win + 1'b1;
               r_state   <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign o_gnt       = r_gnt;
   assign o_rsp_rdy   = r_rsp_rdy;
   assign o_rsp_err   = r_rsp_err;
   assign o_rsp_rdata = r_rsp_rdata;
   assign o_busy      = r_busy;
   assign o_mem_addr  = r_mem_addr;
   assign o_mem_re    = r_mem_re;
   assign o_mem_we    = r_mem_we;
   assign o_mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_smp_dmem_arbiter.sv
// Directed bench for smp_dmem_arbiter: a 2-port round-robin instance with an 8-cycle timeout and a
// 4-port fixed-priority instance without timeout, each with a latency-programmable d_mem model.
module tb_smp_dmem_arbiter;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   typedef struct {
      int          port;
      bit          we;
      bit          err;
      logic [15:0] addr;
      logic [63:0] wdata;
      logic [63:0] rdata;
   } exp_t;

   // instance 0 (a_*): NUM_CPU=2, RR, timeout 8; instance 1 (b_*): NUM_CPU=4, fixed, no timeout
   logic [1:0]   a_re, a_we, a_gnt, a_rsp;
   logic [31:0]  a_addr;
   logic [127:0] a_wdata;
   logic [3:0]   b_re, b_we, b_gnt, b_rsp;
   logic [63:0]  b_addr;
   logic [255:0] b_wdata;

   logic [3:0]  gnt_v [2];
   logic [3:0]  rsp_v [2];
   logic        err_v [2];
   logic        busy_v [2];
   logic        re_v [2];
   logic        we_v [2];
   logic [15:0] maddr_v [2];
   logic [63:0] mwdata_v [2];
   logic [63:0] rdata_v [2];
   logic        mem_rdy_v [2];
   logic [63:0] mem_rdata_v [2];

   always_comb begin
      gnt_v[0] = {2'b00, a_gnt};
      rsp_v[0] = {2'b00, a_rsp};
      gnt_v[1] = b_gnt;
      rsp_v[1] = b_rsp;
   end

   smp_dmem_arbiter #(.NUM_CPU(2), .ADDR_W(16), .LINE_W(64), .RR_MODE(1), .TIMEOUT_CYC(8)) u_dut_a (
      .clk(clk), .rst_n(rst_n),
      .i_req_re(a_re), .i_req_we(a_we), .i_req_addr(a_addr), .i_req_wdata(a_wdata),
      .o_gnt(a_gnt), .o_rsp_rdy(a_rsp), .o_rsp_err(err_v[0]), .o_rsp_rdata(rdata_v[0]),
      .o_busy(busy_v[0]), .o_mem_addr(maddr_v[0]), .o_mem_re(re_v[0]), .o_mem_we(we_v[0]),
      .o_mem_wdata(mwdata_v[0]), .i_mem_rdata(mem_rdata_v[0]), .i_mem_rdy(mem_rdy_v[0])
   );

   smp_dmem_arbiter #(.NUM_CPU(4), .ADDR_W(16), .LINE_W(64), .RR_MODE(0), .TIMEOUT_CYC(0)) u_dut_b (
      .clk(clk), .rst_n(rst_n),
      .i_req_re(b_re), .i_req_we(b_we), .i_req_addr(b_addr), .i_req_wdata(b_wdata),
      .o_gnt(b_gnt), .o_rsp_rdy(b_rsp), .o_rsp_err(err_v[1]), .o_rsp_rdata(rdata_v[1]),
      .o_busy(busy_v[1]), .o_mem_addr(maddr_v[1]), .o_mem_re(re_v[1]), .o_mem_we(we_v[1]),
      .o_mem_wdata(mwdata_v[1]), .i_mem_rdata(mem_rdata_v[1]), .i_mem_rdy(mem_rdy_v[1])
   );

   int          n_cmp = 0;
   int          n_bad = 0;
   exp_t        q0 [$];
   exp_t        q1 [$];
   logic [63:0] mem_m [logic [15:0]];
   int          m_lat [2];
   int          m_cnt [2];
   bit          m_pend [2];
   logic [63:0] m_line [2];
   logic [63:0] last_rdata [2];
   int          n_rsp [2];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_bad++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, expv);
      end
   endtask

   function automatic int qsize(input int d);
      return (d == 0) ? q0.size() : q1.size();
   endfunction

   function automatic exp_t qfront(input int d);
      if (d == 0) return q0[0];
      return q1[0];
   endfunction

   task automatic push(input int d, input int port, input bit we, input logic [15:0] addr,
                       input logic [63:0] wdata, input bit err);
      exp_t e;
      e.port  = port;
      e.we    = we;
      e.err   = err;
      e.addr  = addr;
      e.wdata = wdata;
      e.rdata = mem_m.exists(addr) ? mem_m[addr] : 64'h0;
      if (d == 0) q0.push_back(e);
      else        q1.push_back(e);
   endtask

   // Per-cycle: grant sanity, d_mem model, strobe and response scoreboard checks.
   task automatic mon(input int d);
      exp_t        e;
      logic [63:0] er;
      chk("gnt_onehot", 64'($countones(gnt_v[d]) <= 1), 64'h1);
      mem_rdy_v[d]   = 1'b0;
      mem_rdata_v[d] = {4{16'hBAD0}};
      if (m_pend[d]) begin
         m_cnt[d]--;
         if (m_cnt[d] == 0) begin
            mem_rdy_v[d]   = 1'b1;
            mem_rdata_v[d] = m_line[d];
            m_pend[d]      = 1'b0;
         end
      end
      if (re_v[d] || we_v[d]) begin
         if (qsize(d) == 0) begin
            chk("strobe_unexpected", {62'b0, re_v[d], we_v[d]}, 64'h0);
         end else begin
            e = qfront(d);
            chk("issue_gnt", 64'(gnt_v[d]), 64'(4'b0001 << e.port));
            chk("issue_we", 64'(we_v[d]), 64'(e.we));
            chk("issue_re", 64'(re_v[d]), 64'(!e.we));
            chk("issue_addr", 64'(maddr_v[d]), 64'(e.addr));
            if (e.we) chk("issue_wdata", mwdata_v[d], e.wdata);
         end
         if (we_v[d]) mem_m[maddr_v[d]] = mwdata_v[d];
         else         m_line[d] = mem_m.exists(maddr_v[d]) ? mem_m[maddr_v[d]] : 64'h0;
         if (m_lat[d] > 0) begin
            m_pend[d] = 1'b1;
            m_cnt[d]  = m_lat[d];
         end
      end
      if (rsp_v[d] != 4'h0) begin
         if (qsize(d) == 0) begin
            chk("rsp_unexpected", 64'(rsp_v[d]), 64'h0);
         end else begin
            e = qfront(d);
            if (d == 0) void'(q0.pop_front());
            else        void'(q1.pop_front());
            er = (e.we || e.err) ? last_rdata[d] : e.rdata;
            last_rdata[d] = er;
            chk("rsp_port", 64'(rsp_v[d]), 64'(4'b0001 << e.port));
            chk("rsp_err", 64'(err_v[d]), 64'(e.err));
            chk("rsp_rdata", rdata_v[d], er);
            n_rsp[d]++;
         end
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
      mon(0);
      mon(1);
   endtask

   task automatic wait_rsp(input int d, input int port, input int budget, output int n);
      bit got;
      got = 1'b0;
      n   = 0;
      for (int i = 0; i < budget && !got; i++) begin
         cyc();
         n++;
         if (rsp_v[d][port]) got = 1'b1;
      end
      if (!got) chk("rsp_wait", 64'(rsp_v[d][port]), 64'h1);
   endtask

   task automatic wait_count(input int d, input int target, input int budget);
      for (int i = 0; i < budget && n_rsp[d] < target; i++) cyc();
      chk("rsp_count", 64'(n_rsp[d]), 64'(target));
   endtask

   task automatic check_idle(input int d);
      chk("idle_gnt", 64'(gnt_v[d]), 64'h0);
      chk("idle_rsp_rdy", 64'(rsp_v[d]), 64'h0);
      chk("idle_rsp_err", 64'(err_v[d]), 64'h0);
      chk("idle_busy", 64'(busy_v[d]), 64'h0);
      chk("idle_mem_re", 64'(re_v[d]), 64'h0);
      chk("idle_mem_we", 64'(we_v[d]), 64'h0);
      chk("idle_mem_addr", 64'(maddr_v[d]), 64'h0);
      chk("idle_mem_wdata", mwdata_v[d], 64'h0);
      chk("idle_rsp_rdata", rdata_v[d], 64'h0);
   endtask

   initial begin
      int n;
      rst_n   = 1'b0;
      a_re    = '0; a_we = '0; a_addr = '0; a_wdata = '0;
      b_re    = '0; b_we = '0; b_addr = '0; b_wdata = '0;
      for (int d = 0; d < 2; d++) begin
         mem_rdy_v[d] = 1'b0; mem_rdata_v[d] = '0; m_lat[d] = 1; m_cnt[d] = 0;
         m_pend[d] = 1'b0; m_line[d] = '0; last_rdata[d] = '0; n_rsp[d] = 0;
      end
      mem_m[16'h0010] = 64'hDEAD_BEEF_0123_4567;
      mem_m[16'h0100] = 64'h0100_A5A5_5A5A_0100;
      mem_m[16'h0200] = 64'h0200_C3C3_3C3C_0200;
      mem_m[16'h0300] = 64'h0300_0300_0300_0300;
      for (int i = 0; i < 4; i++) mem_m[16'h1000 + 16'(i)] = {4{16'h1000 + 16'(i)}};

      repeat (3) cyc();
      check_idle(0);
      check_idle(1);
      rst_n = 1'b1;
      cyc();

      // single read, port 0, mem_rdy 3 cycles after mem_re
      m_lat[0] = 3;
      push(0, 0, 1'b0, 16'h0010, 64'h0, 1'b0);
      a_addr[15:0] = 16'h0010;
      a_re = 2'b01;
      cyc();
      chk("rd_strobe", 64'(re_v[0]), 64'h1);
      chk("rd_busy", 64'(busy_v[0]), 64'h1);
      wait_rsp(0, 0, 20, n);
      chk("rd_latency", 64'(n), 64'd4);
      a_re = 2'b00;
      cyc();
      chk("rd_after_busy", 64'(busy_v[0]), 64'h0);

      // write from port 1 with re also set; rsp_rdata must keep the last read line
      m_lat[0] = 2;
      push(0, 1, 1'b1, 16'h0ABC, 64'h1111_2222_3333_4444, 1'b0);
      a_addr[31:16]   = 16'h0ABC;
      a_wdata[127:64] = 64'h1111_2222_3333_4444;
      a_re = 2'b10;
      a_we = 2'b10;
      wait_rsp(0, 1, 20, n);
      chk("wr_latency", 64'(n), 64'd4);
      a_re = 2'b00;
      a_we = 2'b00;
      cyc();

      // both ports held: round-robin order 0,1,0,1
      m_lat[0] = 1;
      a_addr = {16'h0200, 16'h0100};
      push(0, 0, 1'b0, 16'h0100, 64'h0, 1'b0);
      push(0, 1, 1'b0, 16'h0200, 64'h0, 1'b0);
      push(0, 0, 1'b0, 16'h0100, 64'h0, 1'b0);
      push(0, 1, 1'b0, 16'h0200, 64'h0, 1'b0);
      a_re = 2'b11;
      wait_count(0, n_rsp[0] + 4, 40);
      a_re = 2'b00;
      cyc();

      // timeout after 8 WAIT cycles; late mem_rdy afterwards is ignored
      m_lat[0] = 0;
      push(0, 0, 1'b0, 16'h0300, 64'h0, 1'b1);
      a_addr[15:0] = 16'h0300;
      a_re = 2'b01;
      wait_rsp(0, 0, 30, n);
      chk("to_latency", 64'(n), 64'd10);
      a_re = 2'b00;
      mem_rdy_v[0] = 1'b1;
      mem_rdata_v[0] = 64'hFFFF_FFFF_FFFF_FFFF;
      cyc();
      mem_rdy_v[0] = 1'b1;
      mem_rdata_v[0] = 64'hFFFF_FFFF_FFFF_FFFF;
      cyc();
      chk("late_rdy_busy", 64'(busy_v[0]), 64'h0);
      chk("late_rdy_rsp", 64'(rsp_v[0]), 64'h0);
      chk("late_rdy_rdata", rdata_v[0], last_rdata[0]);

      // reset in WAIT (pointer is 1, so port 1 holds the grant)
      push(0, 1, 1'b0, 16'h0200, 64'h0, 1'b0);
      a_addr = {16'h0200, 16'h0100};
      a_re = 2'b11;
      cyc();
      cyc();
      chk("pre_reset_gnt", 64'(gnt_v[0]), 64'h2);
      rst_n = 1'b0;
      #1;
      check_idle(0);
      q0.delete();
      m_pend[0] = 1'b0;
      last_rdata[0] = '0;
      cyc();
      cyc();
      chk("in_reset_rsp", 64'(rsp_v[0]), 64'h0);
      rst_n = 1'b1;
      m_lat[0] = 1;
      push(0, 0, 1'b0, 16'h0100, 64'h0, 1'b0);
      wait_rsp(0, 0, 20, n);
      chk("post_reset_latency", 64'(n), 64'd3);
      a_re = 2'b00;
      cyc();

      // fixed priority, 4 ports: 1 and 3 re-request, 1 always wins until port 0 rises
      m_lat[1] = 1;
      b_addr = {16'h1003, 16'h1002, 16'h1001, 16'h1000};
      for (int i = 0; i < 3; i++) push(1, 1, 1'b0, 16'h1001, 64'h0, 1'b0);
      b_re = 4'b1010;
      wait_count(1, n_rsp[1] + 3, 40);
      push(1, 0, 1'b0, 16'h1000, 64'h0, 1'b0);
      push(1, 1, 1'b0, 16'h1001, 64'h0, 1'b0);
      b_re = 4'b1011;
      wait_rsp(1, 0, 10, n);
      chk("p0_next_idle", 64'(n), 64'd4);
      b_re = 4'b1010;
      wait_rsp(1, 1, 10, n);
      b_re = 4'b0000;
      cyc();

      // no timeout configured: long wait, request dropped mid-transaction still completes
      m_lat[1] = 0;
      push(1, 0, 1'b0, 16'h1000, 64'h0, 1'b0);
      b_re = 4'b0001;
      cyc();
      b_re = 4'b0000;
      repeat (20) cyc();
      chk("no_to_busy", 64'(busy_v[1]), 64'h1);
      chk("no_to_gnt", 64'(gnt_v[1]), 64'h1);
      m_pend[1] = 1'b1;
      m_cnt[1]  = 1;
      wait_rsp(1, 0, 5, n);
      chk("drop_latency", 64'(n), 64'd2);
      cyc();
      chk("end_busy_b", 64'(busy_v[1]), 64'h0);
      chk("end_queue_a", 64'(q0.size()), 64'h0);
      chk("end_queue_b", 64'(q1.size()), 64'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
